// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions for the program loader: frame states and length width.
package program_loader_pkg;

    localparam int unsigned LOADER_LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and write-only memory port of the program loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checked program image into CPU memory and
// holds the CPU halted until a verified image has been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned     ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [LOADER_LEN_W:0]   MAX_LEN = {{LOADER_LEN_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [LOADER_LEN_W-1:0] ONE     = {{(LOADER_LEN_W-1){1'b0}}, 1'b1};

    loader_state_e           state;
    logic [7:0]              len_hi;
    logic [LOADER_LEN_W-1:0] len;
    logic [LOADER_LEN_W-1:0] index;
    logic [7:0]              chk;
    logic                    rx_ready_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [7:0]              mem_wdata_q;
    logic                    mem_we_q;

    logic                    xfer;
    logic [LOADER_LEN_W-1:0] rx_len;

    assign xfer   = bus.rx_valid & rx_ready_q;
    assign rx_len = {len_hi, bus.rx_data};

    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_hi      <= '0;
            len         <= '0;
            index       <= '0;
            chk         <= '0;
            rx_ready_q  <= 1'b0;
            busy        <= 1'b0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LEN_HI;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        index      <= '0;
                        chk        <= '0;
                        cpu_hold   <= 1'b1;
                        rx_ready_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= bus.rx_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len <= rx_len;
                        // An image larger than the address space would overwrite itself.
                        if ({1'b0, rx_len} > MAX_LEN) begin
                            state      <= ST_ERROR;
                            error      <= 1'b1;
                            rx_ready_q <= 1'b0;
                            busy       <= 1'b0;
                        end else if (rx_len == '0) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        chk         <= chk ^ bus.rx_data;
                        index       <= index + ONE;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE + index[ADDR_W-1:0];
                        mem_wdata_q <= bus.rx_data;
                        if (index == len - ONE) begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // The final payload write is already on the port before any CHK byte lands here.
                    if (xfer) begin
                        rx_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        if (bus.rx_data == chk) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ST_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    rx_ready_q <= 1'b0;
                    busy       <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (BASE 0 and BASE F0) run in lockstep.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;

    always #5 clock = ~clock;

    program_loader_if #(.ADDR_W(8)) bus0 ();
    program_loader_if #(.ADDR_W(8)) bus1 ();

    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    logic hold0, busy0, done0, err0;
    logic hold1, busy1, done1, err1;

    program_loader #(.ADDR_W(8), .BASE(8'h00)) dut0 (
        .clock(clock), .reset(reset), .start(start), .bus(bus0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
    );

    program_loader #(.ADDR_W(8), .BASE(8'hF0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .bus(bus1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
    );

    int checks = 0;
    int errors = 0;
    int wcount0 = 0;
    int wcount1 = 0;
    logic [7:0] frame_q[$];

    always @(posedge clock) begin
        if (bus0.mem_we === 1'b1) wcount0++;
        if (bus1.mem_we === 1'b1) wcount1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Status vector order: {cpu_hold, busy, done, error, rx_ready}
    task automatic check_status(input string tag, input logic [4:0] exp);
        check({tag, "_st0"}, {hold0, busy0, done0, err0, bus0.rx_ready}, {27'd0, exp});
        check({tag, "_st1"}, {hold1, busy1, done1, err1, bus1.rx_ready}, {27'd0, exp});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit payload, input int idx, input bit gaps);
        int waited;
        logic [7:0] a0;
        logic [7:0] a1;
        if (gaps) begin
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (bus0.rx_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (bus0.rx_ready !== 1'b1) check("rdy_timeout", 32'd0, 32'd1);
        @(negedge clock);
        rx_valid = 1'b0;
        a0 = idx[7:0];
        a1 = 8'hF0 + idx[7:0];
        if (payload) begin
            check("we0", {31'd0, bus0.mem_we}, 32'd1);
            check("addr0", {24'd0, bus0.mem_addr}, {24'd0, a0});
            check("data0", {24'd0, bus0.mem_wdata}, {24'd0, b});
            check("addr1", {24'd0, bus1.mem_addr}, {24'd0, a1});
        end else begin
            check("we_idle", {31'd0, bus0.mem_we}, 32'd0);
        end
    endtask

    task automatic send_frame(input bit gaps, input bit exp_done, input bit start_mid);
        int n;
        int base0;
        int base1;
        int exp_writes;
        bit p;
        n          = {16'd0, frame_q[0], frame_q[1]};
        exp_writes = (n > 256) ? 0 : n;
        base0      = wcount0;
        base1      = wcount1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_status("start", 5'b11001);
        for (int k = 0; k < frame_q.size(); k++) begin
            p = (k >= 2 && k < 2 + n);
            if (start_mid && k == 3) start = 1'b1;
            send_byte(frame_q[k], p, k - 2, gaps);
            start = 1'b0;
        end
        check_status("end", exp_done ? 5'b00100 : 5'b10010);
        check("wcount0", wcount0 - base0, exp_writes);
        check("wcount1", wcount1 - base1, exp_writes);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] d;
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_status("reset", 5'b10000);
        check("rst_we", {31'd0, bus0.mem_we}, 32'd0);
        check("rst_addr", {24'd0, bus0.mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, bus0.mem_wdata}, 32'd0);
        reset = 1'b0;

        // Bytes offered while idle must be ignored
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clock);
        rx_valid = 1'b0;
        check_status("idle_ign", 5'b10000);
        check("idle_wc", wcount0, 32'd0);

        frame_q = {8'h00, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
        send_frame(1'b0, 1'b1, 1'b0);

        frame_q = {8'h00, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_frame(1'b0, 1'b0, 1'b0);

        frame_q = {8'h01, 8'h01};
        send_frame(1'b0, 1'b0, 1'b0);

        frame_q = {8'h00, 8'h00, 8'h00};
        send_frame(1'b0, 1'b1, 1'b0);

        frame_q = {8'h01, 8'h00};
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d = 8'(i * 7 + 3);
            frame_q.push_back(d);
            x = x ^ d;
        end
        frame_q.push_back(x);
        send_frame(1'b0, 1'b1, 1'b0);

        // Abort mid-frame with an asynchronous reset
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h00, 1'b0, 0, 1'b0);
        send_byte(8'h04, 1'b0, 0, 1'b0);
        send_byte(8'h11, 1'b1, 0, 1'b0);
        send_byte(8'h22, 1'b1, 1, 1'b0);
        reset = 1'b1;
        #1;
        check_status("async_rst", 5'b10000);
        check("async_we", {31'd0, bus0.mem_we}, 32'd0);
        @(negedge clock);
        check_status("rst_hold", 5'b10000);
        reset = 1'b0;
        @(negedge clock);
        frame_q = {8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frame(1'b0, 1'b1, 1'b0);

        // Gappy rx_valid plus a start pulse mid-frame
        frame_q = {8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
        send_frame(1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
